// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator; done and flags appear 1 cycle after the WIDTH-th accepted pair.
// Backpressure: bit_ready is high only in SHIFT, bit_valid=0 stalls indefinitely without losing state.
module serial_comparator #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic AgreaterB,
    output logic AlessB,
    output logic AequalB
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          dec_q;
    logic          gt_q;
    logic          pend_q;
    logic          ready_q;
    logic          done_q;
    logic          gt_flag_q;
    logic          lt_flag_q;
    logic          eq_flag_q;

    logic          dec_d;
    logic          gt_d;
    logic          last_bit;

    // MSB-first keeps the first difference; LSB-first lets each later difference overwrite.
    always_comb begin
        dec_d = dec_q;
        gt_d  = gt_q;
        if ((a_bit != b_bit) && (!MSB_FIRST || !dec_q)) begin
            dec_d = 1'b1;
            gt_d  = a_bit;
        end
    end

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dec_q     <= 1'b0;
            gt_q      <= 1'b0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            gt_flag_q <= 1'b0;
            lt_flag_q <= 1'b0;
            eq_flag_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start || pend_q) begin
                        state_q   <= SHIFT;
                        ready_q   <= 1'b1;
                        cnt_q     <= '0;
                        dec_q     <= 1'b0;
                        gt_q      <= 1'b0;
                        pend_q    <= 1'b0;
                        gt_flag_q <= 1'b0;
                        lt_flag_q <= 1'b0;
                        eq_flag_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        cnt_q <= '0;
                        dec_q <= 1'b0;
                        gt_q  <= 1'b0;
                    end else if (bit_valid) begin
                        dec_q <= dec_d;
                        gt_q  <= gt_d;
                        if (last_bit) begin
                            // Flags load together with done so they are valid during the DONE cycle.
                            state_q   <= DONE;
                            ready_q   <= 1'b0;
                            done_q    <= 1'b1;
                            gt_flag_q <= dec_d & gt_d;
                            lt_flag_q <= dec_d & ~gt_d;
                            eq_flag_q <= ~dec_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    pend_q  <= start;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_ready = ready_q;
    assign busy      = ready_q;
    assign done      = done_q;
    assign AgreaterB = gt_flag_q;
    assign AlessB    = lt_flag_q;
    assign AequalB   = eq_flag_q;
endmodule
